// File: rtl/common_pkg.sv
// Shared types and constants for the boot-time UART flash loader.
package common;

    // Marker byte that starts every image header.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Loader sequencing: sync hunt, 16-bit count, word assembly, write, terminal.
    typedef enum logic [2:0] {
        WAIT_SYNC,
        CNT_LO,
        CNT_HI,
        WORD,
        WRITE,
        DONE
    } loader_state_t;

    // UART receiver bit-phase tracking.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting
// start detection. Emits a one-cycle byte_valid or frame_err per frame.
module uart_rx
    import common::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    // Bit timer: counter restarts at each sample point so every sample lands mid-bit.
    always_comb begin
        st_d         = st_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) st_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A start bit that is already high again at its midpoint was noise.
                    st_d  = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d        = '0;
                    st_d         = RX_IDLE;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    // Synchronizer, edge history and receiver state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            st_q         <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_flash_loader.sv
// Boot loader: receives A5, count(LE16), then count little-endian words over
// UART and writes them to consecutive flash word addresses, holding the core
// in reset until the image is complete.
module uart_flash_loader
    import common::*;
#(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             flash_en,
    output logic             cpu_rst,
    output logic             done,
    output logic             error
);

    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    loader_state_t    state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      idx_q, idx_d;
    logic [23:0]      word_q, word_d;   // first three bytes; the fourth goes straight out
    logic [1:0]       nbyte_q, nbyte_d;
    logic             error_q, error_d;
    logic             flash_en_q, flash_en_d;
    logic [WIDTH-1:0] flash_addr_q, flash_addr_d;
    logic [WIDTH-1:0] flash_data_q, flash_data_d;

    // Loader sequencing; the write port is loaded on the 4th byte so it is valid with flash_en.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        word_d       = word_q;
        nbyte_d      = nbyte_q;
        error_d      = error_q;
        flash_en_d   = 1'b0;
        flash_addr_d = flash_addr_q;
        flash_data_d = flash_data_q;
        if (frame_err && state_q != DONE) begin
            // Abandon the image in progress; completed writes stay in flash.
            error_d = 1'b1;
            state_d = WAIT_SYNC;
            cnt_d   = '0;
            word_d  = '0;
            nbyte_d = '0;
        end else begin
            case (state_q)
                WAIT_SYNC: begin
                    if (byte_valid && byte_data == SYNC_BYTE) begin
                        error_d = 1'b0;
                        idx_d   = '0;
                        state_d = CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (byte_valid) begin
                        cnt_d[7:0] = byte_data;
                        state_d    = CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (byte_valid) begin
                        cnt_d[15:8] = byte_data;
                        nbyte_d     = '0;
                        state_d     = ({byte_data, cnt_q[7:0]} == 16'd0) ? DONE : WORD;
                    end
                end
                WORD: begin
                    if (byte_valid) begin
                        nbyte_d = nbyte_q + 1'b1;
                        case (nbyte_q)
                            2'd0:    word_d[7:0]   = byte_data;
                            2'd1:    word_d[15:8]  = byte_data;
                            2'd2:    word_d[23:16] = byte_data;
                            default: begin
                                flash_en_d   = 1'b1;
                                flash_addr_d = WIDTH'({idx_q, 2'b00});
                                flash_data_d = WIDTH'({byte_data, word_q});
                                state_d      = WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    idx_d   = idx_q + 16'd1;
                    state_d = (idx_q + 16'd1 == cnt_q) ? DONE : WORD;
                end
                DONE:    state_d = DONE;
                default: state_d = WAIT_SYNC;
            endcase
        end
    end

    // Loader state, counters and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_SYNC;
            cnt_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            nbyte_q      <= '0;
            error_q      <= 1'b0;
            flash_en_q   <= 1'b0;
            flash_addr_q <= '0;
            flash_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            nbyte_q      <= nbyte_d;
            error_q      <= error_d;
            flash_en_q   <= flash_en_d;
            flash_addr_q <= flash_addr_d;
            flash_data_q <= flash_data_d;
        end
    end

    assign flash_en   = flash_en_q;
    assign flash_addr = flash_addr_q;
    assign flash_data = flash_data_q;
    assign done       = (state_q == DONE);
    assign cpu_rst    = (state_q != DONE);
    assign error      = error_q;

endmodule

// File: tb/tb_uart_flash_loader.sv
// Scoreboard bench for uart_flash_loader at CLKS_PER_BIT = 4.
module tb_uart_flash_loader;

    localparam int CPB = 4;
    localparam int W   = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx;
    logic [W-1:0] flash_addr, flash_data;
    logic         flash_en, cpu_rst, done, error;

    uart_flash_loader #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .flash_en   (flash_en),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    int   bv_count = 0;
    int   bytes_sent = 0;
    logic done_prev = 1'b0, en_prev = 1'b0, bv_prev = 1'b0;
    bit   exp_zero = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: pops expected writes on each strobe and checks completion timing.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut.u_rx.byte_valid) bv_count++;
            if (flash_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {31'd0, flash_en}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", flash_addr, mon_e.addr);
                    chk("wr_data", flash_data, mon_e.data);
                    chk("wr_cpu_rst_held", {31'd0, cpu_rst}, 32'd1);
                end
            end
            if (done && !done_prev) begin
                chk("done_timing", {31'd0, exp_zero ? bv_prev : en_prev}, 32'd1);
                chk("cpu_rst_fall", {31'd0, cpu_rst}, 32'd0);
            end
        end
        done_prev = done;
        en_prev   = flash_en;
        bv_prev   = dut.u_rx.byte_valid;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        if (stop) bytes_sent++;
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Pulse reset and check every output one edge into it.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        chk({tag, "_flash_en"},   {31'd0, flash_en}, 32'd0);
        chk({tag, "_flash_addr"}, flash_addr, 32'd0);
        chk({tag, "_flash_data"}, flash_data, 32'd0);
        chk({tag, "_cpu_rst"},    {31'd0, cpu_rst}, 32'd1);
        chk({tag, "_done"},       {31'd0, done}, 32'd0);
        chk({tag, "_error"},      {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_zero = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        do_reset("reset");

        // Normal two-word load.
        push_exp(32'd0, 32'h02402783);
        push_exp(32'd4, 32'h00c64633);
        send_hdr(16'd2);
        send_word(32'h02402783);
        send_word(32'h00c64633);
        repeat (10) @(negedge clk);
        chk("normal_done",      {31'd0, done}, 32'd1);
        chk("normal_cpu_rst",   {31'd0, cpu_rst}, 32'd0);
        chk("normal_error",     {31'd0, error}, 32'd0);
        chk("normal_addr_hold", flash_addr, 32'd4);
        chk("normal_data_hold", flash_data, 32'h00c64633);
        chk("normal_pending",   exp_q.size(), 32'd0);

        // Zero count after junk bytes.
        do_reset("rst_zero");
        exp_zero = 1'b1;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_hdr(16'd0);
        repeat (5) @(negedge clk);
        chk("zero_done",  {31'd0, done}, 32'd1);
        chk("zero_error", {31'd0, error}, 32'd0);

        // Framing error mid-word, then recovery.
        do_reset("rst_frame");
        send_hdr(16'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33, 1'b0);
        repeat (5) @(negedge clk);
        chk("ferr_error",   {31'd0, error}, 32'd1);
        chk("ferr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("ferr_done",    {31'd0, done}, 32'd0);
        send_byte(8'hA5);
        chk("ferr_sync_clears", {31'd0, error}, 32'd0);
        push_exp(32'd0, 32'h0000006f);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'h0000006f);
        repeat (5) @(negedge clk);
        chk("ferr_recover_done", {31'd0, done}, 32'd1);

        // One-cycle start glitch, then a good load.
        do_reset("rst_glitch");
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_error",    {31'd0, error}, 32'd0);
        chk("glitch_no_byte",  bv_count, bytes_sent);
        push_exp(32'd0, 32'hefbeadde);
        send_hdr(16'd1);
        send_word(32'hefbeadde);
        repeat (5) @(negedge clk);
        chk("glitch_load_done", {31'd0, done}, 32'd1);

        // Reset two bytes into the second word, then reload from address 0.
        do_reset("rst_mw_pre");
        push_exp(32'd0, 32'h11223344);
        send_hdr(16'd2);
        send_word(32'h11223344);
        send_byte(8'h55);
        send_byte(8'h66);
        chk("midword_not_done", {31'd0, done}, 32'd0);
        do_reset("rst_midword");
        push_exp(32'd0, 32'h0badf00d);
        send_hdr(16'd1);
        send_word(32'h0badf00d);
        repeat (5) @(negedge clk);
        chk("reload_done", {31'd0, done}, 32'd1);

        // Traffic after completion is ignored.
        send_hdr(16'd1);
        send_word(32'h12345678);
        repeat (5) @(negedge clk);
        chk("post_done",      {31'd0, done}, 32'd1);
        chk("post_cpu_rst",   {31'd0, cpu_rst}, 32'd0);
        chk("post_data_hold", flash_data, 32'h0badf00d);
        chk("final_pending",  exp_q.size(), 32'd0);
        chk("byte_count",     bv_count, bytes_sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
